// File: rtl/mc_pkg.sv
// Shared constants and the control-vector type for the multi-cycle MIPS-subset controller.
// Used by multicycle_control and mc_state_decode.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEM_ADR = 4'd2;
    localparam logic [3:0] ST_MEM_RD  = 4'd3;
    localparam logic [3:0] ST_MEM_WB  = 4'd4;
    localparam logic [3:0] ST_MEM_WR  = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_ALU_WB  = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_ADDI_EX = 4'd9;
    localparam logic [3:0] ST_ADDI_WB = 4'd10;
    localparam logic [3:0] ST_JUMP    = 4'd11;
    localparam logic [3:0] ST_TRAP    = 4'd12;

    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_state_decode.sv
// Combinational map from controller state (plus mem_ready, zero, is_bne) to datapath controls.
module mc_state_decode
    import mc_pkg::*;
#(
    parameter logic [1:0] PC_INC_SEL = SRC_B_FOUR
) (
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic       is_bne,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = PC_INC_SEL;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            // Branch target is precomputed while the opcode is being decoded.
            ST_DECODE:  ctrl.alu_src_b = SRC_B_IMM_SHL2;
            ST_MEM_ADR, ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_ADDI_WB: ctrl.reg_write = 1'b1;
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALU_OUT;
                ctrl.pc_en     = zero ^ is_bne;
            end
            ST_JUMP: begin
                ctrl.pc_src = PC_SRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            ST_TRAP:    ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: state register and next-state logic; outputs come from mc_state_decode.
// Optional MULTICYCLE_BNE_EN adds BNE support through a registered is_bne flag.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4 when memory is ready
// DECODE  | dispatch on opcode, precompute branch target
// MEM_ADR | compute load/store address
// MEM_RD  | load data read, waits on mem_ready
// MEM_WB  | write load data to rt
// MEM_WR  | store data write, waits on mem_ready
// EXEC    | R-type ALU operation
// ALU_WB  | write ALU result to rd
// BRANCH  | compare and conditionally load branch target
// ADDI_EX | add immediate
// ADDI_WB | write ADDI result to rt
// JUMP    | load jump target
// TRAP    | unsupported opcode
module multicycle_control
    import mc_pkg::*;
#(
    parameter logic [1:0] PC_INC_SEL  = 2'b01,
    parameter bit         TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] state_cur;
    logic       is_bne;
    ctrl_t      ctrl;

    // Reset forces FETCH outputs in the reset cycle itself, dropping any pending write.
    assign state_cur = rst ? ST_FETCH : state_q;
    assign state     = state_cur;

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:   state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = ST_EXEC;
                    OP_ADDI:       state_d = ST_ADDI_EX;
                    OP_LW, OP_SW:  state_d = ST_MEM_ADR;
                    OP_BEQ:        state_d = ST_BRANCH;
                    OP_J:          state_d = ST_JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:        state_d = ST_BRANCH;
`else
                    OP_BNE:        state_d = ST_TRAP;
`endif
                    default:       state_d = ST_TRAP;
                endcase
            end
            ST_MEM_ADR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:  state_d = ST_FETCH;
            ST_MEM_WR:  state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC:    state_d = ST_ALU_WB;
            ST_ALU_WB:  state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_ADDI_EX: state_d = ST_ADDI_WB;
            ST_ADDI_WB: state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_TRAP:    state_d = TRAP_STICKY ? ST_TRAP : ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

`ifdef MULTICYCLE_BNE_EN
    logic is_bne_q;

    always_ff @(posedge clk) begin
        if (rst)                         is_bne_q <= 1'b0;
        else if (state_q == ST_DECODE)   is_bne_q <= (opcode == OP_BNE);
    end

    assign is_bne = is_bne_q;
`else
    assign is_bne = 1'b0;
`endif

    mc_state_decode #(
        .PC_INC_SEL (PC_INC_SEL)
    ) u_decode (
        .state     (state_cur),
        .mem_ready (mem_ready),
        .zero      (zero),
        .is_bne    (is_bne),
        .ctrl      (ctrl)
    );

    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign pc_en      = ctrl.pc_en;
    assign illegal    = ctrl.illegal;

endmodule
